// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the writeback slice:
// load funct3 codes, writeback FSM states and XLEN.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE,
    WAIT_MEM
  } wb_state_t;

endpackage

// File: rtl/wb_load_align.sv
// Load data alignment and extension, plus the
// misaligned/illegal-funct3 flag used at accept time.
module wb_load_align
  import rv32_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic            bad
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr, 3'b000} +: 8];
  assign half_sel = addr[1] ? rdata[31:16]
                            : rdata[15:0];

  // Decode load type into extended data and error flag
  always_comb begin
    wdata = '0;
    bad   = 1'b0;
    unique case (1'b1)
      (funct3 == F3_LB):
        wdata = {{24{byte_sel[7]}}, byte_sel};
      (funct3 == F3_LBU):
        wdata = {24'h0, byte_sel};
      (funct3 == F3_LH): begin
        wdata = {{16{half_sel[15]}}, half_sel};
        bad   = addr[0];
      end
      (funct3 == F3_LHU): begin
        wdata = {16'h0, half_sel};
        bad   = addr[0];
      end
      (funct3 == F3_LW): begin
        wdata = rdata;
        bad   = (addr != 2'b00);
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage driving the register-file write port.
// Optional retired-instruction counter: define WB_INSTRET_EN.
module wb_stage
  import rv32_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic [XLEN-1:0]  in_result,
  input  logic             in_is_load,
  input  logic [2:0]       in_funct3,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             load_err,
  output logic [CNT_W-1:0] instret
);

  wb_state_t       state;
  wb_state_t       state_n;
  logic [4:0]      rd_q;
  logic [2:0]      f3_q;
  logic [1:0]      addr_q;
  logic            accept;
  logic            go_alu;
  logic            go_ld;
  logic            go_err;
  logic            ld_done;
  logic            retire;
  logic [2:0]      al_f3;
  logic [1:0]      al_addr;
  logic [XLEN-1:0] al_wdata;
  logic            al_bad;
  logic [4:0]      wr_rd;
  logic [XLEN-1:0] wr_data;

  assign in_ready = (state != WAIT_MEM);
  assign accept   = in_valid && in_ready;

  // One aligner: checks the incoming load while idle,
  // aligns the response using latched fields while waiting.
  assign al_f3   = (state == WAIT_MEM) ? f3_q
                                       : in_funct3;
  assign al_addr = (state == WAIT_MEM) ? addr_q
                                       : in_result[1:0];

  wb_load_align u_align (
    .funct3 (al_f3),
    .addr   (al_addr),
    .rdata  (mem_rdata),
    .wdata  (al_wdata),
    .bad    (al_bad)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and per-cycle retire/error events
  always_comb begin
    state_n = state;
    go_alu  = 1'b0;
    go_ld   = 1'b0;
    go_err  = 1'b0;
    ld_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (!in_is_load) begin
            go_alu = 1'b1;
          end else if (al_bad) begin
            go_err = 1'b1;
          end else begin
            go_ld   = 1'b1;
            state_n = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          ld_done = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign retire  = go_alu || ld_done;
  assign wr_rd   = go_alu ? in_rd : rd_q;
  assign wr_data = go_alu ? in_result : al_wdata;

  // Latch the fields of a pending load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q   <= '0;
      f3_q   <= '0;
      addr_q <= '0;
    end else if (go_ld) begin
      rd_q   <= in_rd;
      f3_q   <= in_funct3;
      addr_q <= in_result[1:0];
    end
  end

  // Register-file write port; x0 never written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
      load_err <= 1'b0;
    end else begin
      rf_we    <= retire && (wr_rd != 5'd0);
      load_err <= go_err;
      if (retire && (wr_rd != 5'd0)) begin
        rf_rd    <= wr_rd;
        rf_wdata <= wr_data;
      end
    end
  end

`ifdef WB_INSTRET_EN
  // Count retirements, visible in the write cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      instret <= '0;
    else if (retire) instret <= instret + 1'b1;
  end
`else
  assign instret = '0;
`endif

endmodule
